execute_feedback_unit: RTL and testbench
========================================

EXECUTE_FEEDBACK_UNIT -- requirements
Module: execute_feedback

Interface
REQ-001 Parameters SHALL come from the shared config macros, not module parameters; each line gives name, default, meaning:
- ALU_UNIT_NUM, 2, ALU channel count
- BRU_UNIT_NUM, 1, BRU channel count
- CSR_UNIT_NUM, 1, CSR channel count
- DIV_UNIT_NUM, 1, DIV channel count
- LSU_UNIT_NUM, 1, LSU channel count
- MUL_UNIT_NUM, 2, MUL channel count
- EXECUTE_UNIT_NUM, sum of the six above, total channel count
REQ-002 Ports SHALL be as follows; each line gives name, direction, width, meaning:
- clk  in  1  clock; one clock only.
- rst  in  1  reset, asynchronous, active-high.
- alu_execute_channel_feedback_pack  in  execute_feedback_channel_t[0:ALU_UNIT_NUM-1]  ALU feedback.
- bru_execute_channel_feedback_pack  in  execute_feedback_channel_t[0:BRU_UNIT_NUM-1]  BRU feedback.
- csr_execute_channel_feedback_pack  in  execute_feedback_channel_t[0:CSR_UNIT_NUM-1]  CSR feedback.
- div_execute_channel_feedback_pack  in  execute_feedback_channel_t[0:DIV_UNIT_NUM-1]  DIV feedback.
- lsu_execute_channel_feedback_pack  in  execute_feedback_channel_t[0:LSU_UNIT_NUM-1]  LSU feedback.
- mul_execute_channel_feedback_pack  in  execute_feedback_channel_t[0:MUL_UNIT_NUM-1]  MUL feedback.
- execute_feedback_pack  out  execute_feedback_pack_t  merged feedback; field channel[0:EXECUTE_UNIT_NUM-1].
- feedback_conflict  out  1  sticky flag: duplicate phy_id writeback detected.
REQ-003 execute_feedback_channel_t SHALL contain enable (1 bit), phy_id (PHY_REG_ID_WIDTH) and value (32 bits).

Function
REQ-004 execute_feedback_pack.channel SHALL be a purely combinational concatenation with zero-cycle latency and no dependence on clk or rst.
REQ-005 Channel ordering SHALL be ALU, BRU, CSR, DIV, LSU, MUL.
REQ-006 Index mapping SHALL be as follows:
- ALU i -> channel[i].
- BRU i -> channel[ALU_UNIT_NUM+i].
- CSR i -> channel[ALU+BRU+i].
- DIV i -> channel[ALU+BRU+CSR+i].
- LSU i -> channel[ALU+BRU+CSR+DIV+i].
- MUL i -> channel[ALU+BRU+CSR+DIV+LSU+i].
REQ-007 Every field (enable, phy_id, value) SHALL be copied bit-exactly; no masking, no gating by enable.
REQ-008 The mapping SHALL hold for any unit count of 1 or more via generate loops; the code SHALL contain no hardcoded indices.
REQ-009 A conflict SHALL exist in a cycle when two distinct output channels both have enable=1 and equal phy_id.
REQ-010 On a rising clk edge where a conflict exists, feedback_conflict SHALL be set to 1.
REQ-011 Once set, feedback_conflict SHALL remain 1 until rst.
REQ-012 feedback_conflict SHALL use the registered value only, so it becomes visible one cycle after the conflict.
REQ-013 Channels with enable=0 SHALL never contribute to a conflict, even when their phy_id values match.
REQ-014 phy_id equal to 0 SHALL be compared like any other value.

Reset
REQ-015 While rst=1, feedback_conflict SHALL be 0 (asynchronous clear).
REQ-016 execute_feedback_pack SHALL be unaffected by rst and SHALL keep tracking its inputs during reset.
REQ-017 A conflict on the first clk edge after rst deasserts SHALL be captured.

Structure
REQ-018 execute_feedback_channel_t and execute_feedback_pack_t SHALL live in common.svh.
REQ-019 The *_UNIT_NUM, EXECUTE_UNIT_NUM and PHY_REG_ID_WIDTH macros SHALL live in config.svh.
REQ-020 Conflict detection SHALL be a sub-module, execute_feedback_conflict_check: input is the merged pack plus clk/rst, output is the sticky flag.

Verification
REQ-021 Unit k's i-th value = running global index (ALU 0..1, BRU 2, ...), enable=0 -> after 10 time units, channel[n].value == n for all n and feedback_conflict stays 0.
REQ-022 Every input value = 0xFFFFFFFF, phy_id = max, enable=1 on one channel only -> all fields propagate in the same time step with no clock edge, and no conflict.
REQ-023 ALU0 and MUL1 enabled with phy_id=5 -> feedback_conflict is 0 before the edge, 1 after the next clk edge, and stays 1 while inputs return to idle.
REQ-024 Same phy_id=5 on two channels with one enable=0 -> feedback_conflict remains 0.
REQ-025 Set the conflict flag, assert rst asynchronously mid-cycle -> flag drops to 0 immediately while execute_feedback_pack keeps following inputs.
REQ-026 Random inputs over 1000 cycles -> reference-model comparison of the index mapping shows zero mismatches.

Source files
------------

// File: rtl/execute_feedback_unit_pkg.sv
// Shared configuration and payload types for the execute feedback merge.
// Unit counts are macros so a config header can override them before this package is compiled.
`ifndef ALU_UNIT_NUM
`define ALU_UNIT_NUM 2
`endif
`ifndef BRU_UNIT_NUM
`define BRU_UNIT_NUM 1
`endif
`ifndef CSR_UNIT_NUM
`define CSR_UNIT_NUM 1
`endif
`ifndef DIV_UNIT_NUM
`define DIV_UNIT_NUM 1
`endif
`ifndef LSU_UNIT_NUM
`define LSU_UNIT_NUM 1
`endif
`ifndef MUL_UNIT_NUM
`define MUL_UNIT_NUM 2
`endif
`ifndef EXECUTE_UNIT_NUM
`define EXECUTE_UNIT_NUM (`ALU_UNIT_NUM + `BRU_UNIT_NUM + `CSR_UNIT_NUM + `DIV_UNIT_NUM + `LSU_UNIT_NUM + `MUL_UNIT_NUM)
`endif
`ifndef PHY_REG_ID_WIDTH
`define PHY_REG_ID_WIDTH 7
`endif

package execute_feedback_unit_pkg;

    localparam int unsigned ALU_UNIT_NUM     = `ALU_UNIT_NUM;
    localparam int unsigned BRU_UNIT_NUM     = `BRU_UNIT_NUM;
    localparam int unsigned CSR_UNIT_NUM     = `CSR_UNIT_NUM;
    localparam int unsigned DIV_UNIT_NUM     = `DIV_UNIT_NUM;
    localparam int unsigned LSU_UNIT_NUM     = `LSU_UNIT_NUM;
    localparam int unsigned MUL_UNIT_NUM     = `MUL_UNIT_NUM;
    localparam int unsigned EXECUTE_UNIT_NUM = `EXECUTE_UNIT_NUM;
    localparam int unsigned PHY_REG_ID_WIDTH = `PHY_REG_ID_WIDTH;
    localparam int unsigned VALUE_WIDTH      = 32;

    typedef struct packed {
        logic                        enable;
        logic [PHY_REG_ID_WIDTH-1:0] phy_id;
        logic [VALUE_WIDTH-1:0]      value;
    } execute_feedback_channel_t;

    typedef struct packed {
        execute_feedback_channel_t [0:EXECUTE_UNIT_NUM-1] channel;
    } execute_feedback_pack_t;

    typedef enum logic [2:0] {
        UNIT_ALU,
        UNIT_BRU,
        UNIT_CSR,
        UNIT_DIV,
        UNIT_LSU,
        UNIT_MUL
    } execute_unit_kind_t;

    // First merged channel index owned by a unit kind; kinds are packed in enum order.
    function automatic int unsigned unit_base(input execute_unit_kind_t kind);
        int unsigned base;
        base = 0;
        if (kind > UNIT_ALU) base = base + ALU_UNIT_NUM;
        if (kind > UNIT_BRU) base = base + BRU_UNIT_NUM;
        if (kind > UNIT_CSR) base = base + CSR_UNIT_NUM;
        if (kind > UNIT_DIV) base = base + DIV_UNIT_NUM;
        if (kind > UNIT_LSU) base = base + LSU_UNIT_NUM;
        return base;
    endfunction

endpackage

// File: rtl/execute_feedback_unit_conflict_check.sv
// Sticky detector for two enabled merged channels writing back the same phy_id.
module execute_feedback_conflict_check
    import execute_feedback_unit_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  execute_feedback_pack_t execute_feedback_pack,
    output logic                   feedback_conflict
);

    logic conflict_c;

    // Pairwise compare; disabled channels never participate.
    always_comb begin
        conflict_c = 1'b0;
        for (int unsigned i = 0; i < EXECUTE_UNIT_NUM; i++) begin
            for (int unsigned j = i + 1; j < EXECUTE_UNIT_NUM; j++) begin
                if (execute_feedback_pack.channel[i].enable &&
                    execute_feedback_pack.channel[j].enable &&
                    (execute_feedback_pack.channel[i].phy_id ==
                     execute_feedback_pack.channel[j].phy_id)) begin
                    conflict_c = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            feedback_conflict <= 1'b0;
        end else if (conflict_c) begin
            feedback_conflict <= 1'b1;
        end
    end

endmodule

// File: rtl/execute_feedback_unit.sv
// Merges per-unit execute feedback into one channel array (ALU, BRU, CSR, DIV, LSU, MUL order).
module execute_feedback_unit
    import execute_feedback_unit_pkg::*;
(
    input  logic                                         clk,
    input  logic                                         rst,
    input  execute_feedback_channel_t [0:ALU_UNIT_NUM-1] alu_execute_channel_feedback_pack,
    input  execute_feedback_channel_t [0:BRU_UNIT_NUM-1] bru_execute_channel_feedback_pack,
    input  execute_feedback_channel_t [0:CSR_UNIT_NUM-1] csr_execute_channel_feedback_pack,
    input  execute_feedback_channel_t [0:DIV_UNIT_NUM-1] div_execute_channel_feedback_pack,
    input  execute_feedback_channel_t [0:LSU_UNIT_NUM-1] lsu_execute_channel_feedback_pack,
    input  execute_feedback_channel_t [0:MUL_UNIT_NUM-1] mul_execute_channel_feedback_pack,
    output execute_feedback_pack_t                       execute_feedback_pack,
    output logic                                         feedback_conflict
);

    localparam int unsigned ALU_BASE = unit_base(UNIT_ALU);
    localparam int unsigned BRU_BASE = unit_base(UNIT_BRU);
    localparam int unsigned CSR_BASE = unit_base(UNIT_CSR);
    localparam int unsigned DIV_BASE = unit_base(UNIT_DIV);
    localparam int unsigned LSU_BASE = unit_base(UNIT_LSU);
    localparam int unsigned MUL_BASE = unit_base(UNIT_MUL);

    // Pure wiring: fields pass untouched, independent of enable, clk and rst.
    for (genvar i = 0; i < ALU_UNIT_NUM; i++) begin : g_alu
        assign execute_feedback_pack.channel[ALU_BASE + i] = alu_execute_channel_feedback_pack[i];
    end
    for (genvar i = 0; i < BRU_UNIT_NUM; i++) begin : g_bru
        assign execute_feedback_pack.channel[BRU_BASE + i] = bru_execute_channel_feedback_pack[i];
    end
    for (genvar i = 0; i < CSR_UNIT_NUM; i++) begin : g_csr
        assign execute_feedback_pack.channel[CSR_BASE + i] = csr_execute_channel_feedback_pack[i];
    end
    for (genvar i = 0; i < DIV_UNIT_NUM; i++) begin : g_div
        assign execute_feedback_pack.channel[DIV_BASE + i] = div_execute_channel_feedback_pack[i];
    end
    for (genvar i = 0; i < LSU_UNIT_NUM; i++) begin : g_lsu
        assign execute_feedback_pack.channel[LSU_BASE + i] = lsu_execute_channel_feedback_pack[i];
    end
    for (genvar i = 0; i < MUL_UNIT_NUM; i++) begin : g_mul
        assign execute_feedback_pack.channel[MUL_BASE + i] = mul_execute_channel_feedback_pack[i];
    end

    execute_feedback_conflict_check u_conflict_check (
        .clk                   (clk),
        .rst                   (rst),
        .execute_feedback_pack (execute_feedback_pack),
        .feedback_conflict     (feedback_conflict)
    );

endmodule

// File: tb/tb_execute_feedback_unit.sv
// Scoreboard bench: stimulus queues expected merged pack / conflict flag, a monitor compares.
module tb_execute_feedback_unit;
    import execute_feedback_unit_pkg::*;

    logic clk;
    logic rst;
    execute_feedback_channel_t [0:ALU_UNIT_NUM-1] alu_in;
    execute_feedback_channel_t [0:BRU_UNIT_NUM-1] bru_in;
    execute_feedback_channel_t [0:CSR_UNIT_NUM-1] csr_in;
    execute_feedback_channel_t [0:DIV_UNIT_NUM-1] div_in;
    execute_feedback_channel_t [0:LSU_UNIT_NUM-1] lsu_in;
    execute_feedback_channel_t [0:MUL_UNIT_NUM-1] mul_in;
    execute_feedback_pack_t pack_out;
    logic conflict_out;

    execute_feedback_unit dut (
        .clk                               (clk),
        .rst                               (rst),
        .alu_execute_channel_feedback_pack (alu_in),
        .bru_execute_channel_feedback_pack (bru_in),
        .csr_execute_channel_feedback_pack (csr_in),
        .div_execute_channel_feedback_pack (div_in),
        .lsu_execute_channel_feedback_pack (lsu_in),
        .mul_execute_channel_feedback_pack (mul_in),
        .execute_feedback_pack             (pack_out),
        .feedback_conflict                 (conflict_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string                  name;
        bit                     chk_pack;
        execute_feedback_pack_t pack;
        logic                   conflict;
    } sb_item_t;

    sb_item_t sb[$];
    event     sb_ev;
    int       n_checks = 0;
    int       n_pass   = 0;
    logic     sticky_model;

    // Reference: walk the units in order with one running output index.
    function automatic execute_feedback_pack_t expected_pack();
        execute_feedback_pack_t p;
        int n;
        p = '0;
        n = 0;
        for (int i = 0; i < ALU_UNIT_NUM; i++) begin p.channel[n] = alu_in[i]; n++; end
        for (int i = 0; i < BRU_UNIT_NUM; i++) begin p.channel[n] = bru_in[i]; n++; end
        for (int i = 0; i < CSR_UNIT_NUM; i++) begin p.channel[n] = csr_in[i]; n++; end
        for (int i = 0; i < DIV_UNIT_NUM; i++) begin p.channel[n] = div_in[i]; n++; end
        for (int i = 0; i < LSU_UNIT_NUM; i++) begin p.channel[n] = lsu_in[i]; n++; end
        for (int i = 0; i < MUL_UNIT_NUM; i++) begin p.channel[n] = mul_in[i]; n++; end
        return p;
    endfunction

    function automatic logic model_conflict(input execute_feedback_pack_t p);
        logic c;
        c = 1'b0;
        for (int i = 0; i < EXECUTE_UNIT_NUM; i++)
            for (int j = 0; j < EXECUTE_UNIT_NUM; j++)
                if (i != j && p.channel[i].enable && p.channel[j].enable &&
                    p.channel[i].phy_id == p.channel[j].phy_id)
                    c = 1'b1;
        return c;
    endfunction

    // Monitor: drain every queued expectation against the live DUT outputs.
    initial begin
        sb_item_t it;
        forever begin
            @(sb_ev);
            while (sb.size() != 0) begin
                it = sb.pop_front();
                if (it.chk_pack) begin
                    n_checks++;
                    if (pack_out === it.pack) n_pass++;
                    else $display("FAIL %s pack: got %h want %h", it.name, pack_out, it.pack);
                end
                n_checks++;
                if (conflict_out === it.conflict) n_pass++;
                else $display("FAIL %s conflict: got %b want %b", it.name, conflict_out, it.conflict);
            end
        end
    end

    task automatic expect_now(input string name, input bit chk_pack, input logic conflict);
        sb_item_t it;
        int k;
        it.name = name;
        it.chk_pack = chk_pack;
        it.pack = expected_pack();
        it.conflict = conflict;
        sb.push_back(it);
        -> sb_ev;
        k = 0;
        while (sb.size() != 0 && k < 20) begin #1; k++; end
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL %s monitor: got pending=%0d want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic set_idle();
        alu_in = '0; bru_in = '0; csr_in = '0; div_in = '0; lsu_in = '0; mul_in = '0;
    endtask

    task automatic set_index_values(input logic en);
        int n;
        n = 0;
        for (int i = 0; i < ALU_UNIT_NUM; i++) begin alu_in[i] = '{en, PHY_REG_ID_WIDTH'(n), 32'(n)}; n++; end
        for (int i = 0; i < BRU_UNIT_NUM; i++) begin bru_in[i] = '{en, PHY_REG_ID_WIDTH'(n), 32'(n)}; n++; end
        for (int i = 0; i < CSR_UNIT_NUM; i++) begin csr_in[i] = '{en, PHY_REG_ID_WIDTH'(n), 32'(n)}; n++; end
        for (int i = 0; i < DIV_UNIT_NUM; i++) begin div_in[i] = '{en, PHY_REG_ID_WIDTH'(n), 32'(n)}; n++; end
        for (int i = 0; i < LSU_UNIT_NUM; i++) begin lsu_in[i] = '{en, PHY_REG_ID_WIDTH'(n), 32'(n)}; n++; end
        for (int i = 0; i < MUL_UNIT_NUM; i++) begin mul_in[i] = '{en, PHY_REG_ID_WIDTH'(n), 32'(n)}; n++; end
    endtask

    task automatic check_index_map(input string name);
        execute_feedback_pack_t p;
        p = pack_out;
        for (int n = 0; n < EXECUTE_UNIT_NUM; n++) begin
            n_checks++;
            if (p.channel[n].value === 32'(n)) n_pass++;
            else $display("FAIL %s ch%0d value: got %0d want %0d", name, n, p.channel[n].value, n);
        end
    endtask

    task automatic set_all_max();
        execute_feedback_channel_t c;
        c = '{1'b0, {PHY_REG_ID_WIDTH{1'b1}}, 32'hFFFF_FFFF};
        for (int i = 0; i < ALU_UNIT_NUM; i++) alu_in[i] = c;
        for (int i = 0; i < BRU_UNIT_NUM; i++) bru_in[i] = c;
        for (int i = 0; i < CSR_UNIT_NUM; i++) csr_in[i] = c;
        for (int i = 0; i < DIV_UNIT_NUM; i++) div_in[i] = c;
        for (int i = 0; i < LSU_UNIT_NUM; i++) lsu_in[i] = c;
        for (int i = 0; i < MUL_UNIT_NUM; i++) mul_in[i] = c;
    endtask

    task automatic set_random();
        for (int i = 0; i < ALU_UNIT_NUM; i++) alu_in[i] = execute_feedback_channel_t'({$urandom, $urandom});
        for (int i = 0; i < BRU_UNIT_NUM; i++) bru_in[i] = execute_feedback_channel_t'({$urandom, $urandom});
        for (int i = 0; i < CSR_UNIT_NUM; i++) csr_in[i] = execute_feedback_channel_t'({$urandom, $urandom});
        for (int i = 0; i < DIV_UNIT_NUM; i++) div_in[i] = execute_feedback_channel_t'({$urandom, $urandom});
        for (int i = 0; i < LSU_UNIT_NUM; i++) lsu_in[i] = execute_feedback_channel_t'({$urandom, $urandom});
        for (int i = 0; i < MUL_UNIT_NUM; i++) mul_in[i] = execute_feedback_channel_t'({$urandom, $urandom});
    endtask

    initial begin
        rst = 1'b1;
        set_idle();

        // Reset: flag low, pack tracks inputs even while rst is high.
        @(negedge clk);
        alu_in[1] = '{1'b1, 7'd3, 32'hDEAD_BEEF};
        #1 expect_now("reset", 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        set_idle();

        // Running-index values with enables off: mapping holds, no conflict.
        set_index_values(1'b0);
        #10 check_index_map("index_map");
        expect_now("index_map", 1'b1, 1'b0);
        @(posedge clk); @(negedge clk);
        #1 expect_now("index_map_edge", 1'b0, 1'b0);

        // All-ones with a single enable, checked with no clock edge in between.
        @(posedge clk);
        #2 set_all_max();
        bru_in[0].enable = 1'b1;
        #1 expect_now("all_max_comb", 1'b1, 1'b0);
        @(posedge clk); @(negedge clk);
        #1 expect_now("all_max_edge", 1'b1, 1'b0);

        // ALU0 and MUL1 both write phy 5: flag appears one edge later and sticks.
        @(negedge clk);
        set_idle();
        alu_in[0] = '{1'b1, 7'd5, 32'h0000_0011};
        mul_in[1] = '{1'b1, 7'd5, 32'h0000_0022};
        #1 expect_now("dup5_before", 1'b1, 1'b0);
        @(posedge clk); @(negedge clk);
        #1 expect_now("dup5_after", 1'b1, 1'b1);
        set_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 expect_now("dup5_sticky", 1'b1, 1'b1);

        // Async reset mid-cycle clears the flag at once; pack keeps following.
        @(posedge clk);
        #2 rst = 1'b1;
        csr_in[0] = '{1'b1, 7'd9, 32'h1234_5678};
        #1 expect_now("async_rst", 1'b1, 1'b0);
        alu_in[1] = '{1'b1, 7'd0, 32'hAAAA_5555};
        lsu_in[0] = '{1'b1, 7'd0, 32'h5555_AAAA};
        @(posedge clk); @(negedge clk);
        #1 expect_now("rst_hold_conflict", 1'b1, 1'b0);

        // First edge after reset release captures a phy 0 duplicate.
        rst = 1'b0;
        #1 expect_now("post_rst_before", 1'b1, 1'b0);
        @(posedge clk); @(negedge clk);
        #1 expect_now("post_rst_phy0", 1'b1, 1'b1);

        // Same phy with one side disabled, and disabled matching zeros: no conflict.
        rst = 1'b1;
        set_idle();
        #2 rst = 1'b0;
        alu_in[0] = '{1'b1, 7'd5, 32'h1};
        mul_in[1] = '{1'b0, 7'd5, 32'h2};
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 expect_now("one_disabled", 1'b1, 1'b0);

        // Random mapping sweep with a sticky conflict model.
        rst = 1'b1;
        set_idle();
        #2 rst = 1'b0;
        sticky_model = 1'b0;
        for (int it = 0; it < 1000; it++) begin
            @(negedge clk);
            set_random();
            #1 expect_now("random", 1'b1, sticky_model);
            @(posedge clk);
            sticky_model = sticky_model | model_conflict(expected_pack());
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
